// File: rtl/stretch_sequencer_if.sv
// Host-side config/control bus and output strobes of the stretch sequencer.
interface stretch_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int BURST_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [WIDTH-1:0]   cfg_half_period;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               stop;
  logic               busy;
  logic               stretched;
  logic               edge_pulse;
  logic               done;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_half_period, cfg_burst, start, stop,
    input  cfg_ready, busy, stretched, edge_pulse, done, cfg_err
  );
  modport slave (
    input  cfg_valid, cfg_half_period, cfg_burst, start, stop,
    output cfg_ready, busy, stretched, edge_pulse, done, cfg_err
  );
endinterface

// File: rtl/stretch_sequencer.sv
// Square-wave stretch generator: half-period counter, start/stop, burst mode,
// and config changes that take effect only on half-period boundaries.
module stretch_sequencer #(
  parameter int          WIDTH        = 32,
  parameter int unsigned DEFAULT_HALF = 32'd100000000,
  parameter int          BURST_W      = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  stretch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t             state;
  logic [WIDTH-1:0]   count, active_half, pend_half;
  logic [BURST_W-1:0] active_burst, pend_burst;
  logic [BURST_W:0]   remaining;
  logic               pend_valid;
  logic               busy_q, stretched_q, edge_q, done_q, cfg_err_q, cfg_ready_q;
  logic               xfer, boundary, fin;

  assign bus.busy       = busy_q;
  assign bus.stretched  = stretched_q;
  assign bus.edge_pulse = edge_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.cfg_ready  = cfg_ready_q;

  // fin marks the single cycle that leaves RUN/STOPPING, so a stop that lands
  // on a burst-final boundary still yields exactly one done.
  always_comb begin
    xfer     = bus.cfg_valid && cfg_ready_q;
    boundary = (state != IDLE) && (count == active_half - 1'b1);
    fin      = 1'b0;
    if (state == RUN)
      fin = (bus.stop && !stretched_q) ||
            (boundary && ((remaining == (BURST_W+1)'(1)) || bus.stop));
    else if (state == STOPPING)
      fin = boundary;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      remaining    <= '0;
      active_half  <= WIDTH'(DEFAULT_HALF);
      active_burst <= '0;
      pend_half    <= '0;
      pend_burst   <= '0;
      pend_valid   <= 1'b0;
      busy_q       <= 1'b0;
      stretched_q  <= 1'b0;
      edge_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_ready_q  <= 1'b1;
    end else begin
      edge_q    <= 1'b0;
      done_q    <= fin;
      cfg_err_q <= xfer && (bus.cfg_half_period == '0);

      case (state)
        IDLE: begin
          count       <= '0;
          stretched_q <= 1'b0;
          if (bus.start && !bus.stop) begin
            state     <= RUN;
            busy_q    <= 1'b1;
            remaining <= {active_burst, 1'b0};
          end
        end
        RUN, STOPPING: begin
          if (state == RUN && bus.stop && !stretched_q) begin
            count <= '0;
          end else if (boundary) begin
            count       <= '0;
            stretched_q <= ~stretched_q;
            edge_q      <= 1'b1;
            // remaining==0 means continuous; it never reaches 0 mid-burst
            if (state == RUN && remaining != '0 && !fin)
              remaining <= remaining - 1'b1;
          end else begin
            count <= count + 1'b1;
            if (state == RUN && bus.stop) state <= STOPPING;
          end
          if (fin) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            count  <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      // cfg_ready low implies no transfer, so apply and accept never collide
      if (pend_valid && (state == IDLE || boundary || fin)) begin
        active_half  <= pend_half;
        active_burst <= pend_burst;
        pend_valid   <= 1'b0;
        cfg_ready_q  <= 1'b1;
      end

      if (xfer && bus.cfg_half_period != '0) begin
        if (state == IDLE) begin
          active_half  <= bus.cfg_half_period;
          active_burst <= bus.cfg_burst;
        end else begin
          pend_half   <= bus.cfg_half_period;
          pend_burst  <= bus.cfg_burst;
          pend_valid  <= 1'b1;
          cfg_ready_q <= 1'b0;
        end
      end
    end
  end
endmodule
